// File: rtl/ram_access_ctrl.sv
// Request sequencer in front of a single-port RAM: one outstanding access at a time,
// with parameterised chip-select hold times and a valid/ready response channel.

package ram_access_ctrl_pkg;
    function automatic int addr_bits(input int depth);
        int bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(depth)) bits++;
        return (bits < 1) ? 1 : bits;
    endfunction
endpackage

module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 256,
    parameter int RD_LATENCY = 2,
    parameter int WR_CYCLES  = 1,
    localparam int ADDR_WIDTH = addr_bits(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_was_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_write,
    output logic                  ram_chip_select,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_data_oe,
    input  logic [DATA_WIDTH-1:0] ram_data_in
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t     state;
    logic [3:0] count;
    logic [31:0] addr_ext;
    logic        out_of_range;

    // Unreachable when RAM_DEPTH is a power of two, but kept so odd depths are guarded.
    assign addr_ext     = 32'(req_addr);
    assign out_of_range = (addr_ext >= 32'(RAM_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_error       <= 1'b0;
            rsp_was_write   <= 1'b0;
            ram_address     <= '0;
            ram_write       <= 1'b0;
            ram_chip_select <= 1'b0;
            ram_data_out    <= '0;
            ram_data_oe     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (out_of_range) begin
                            state         <= RESP;
                            rsp_valid     <= 1'b1;
                            rsp_error     <= 1'b1;
                            rsp_rdata     <= '0;
                            rsp_was_write <= req_write;
                        end else if (req_write) begin
                            state           <= WRITE;
                            count           <= 4'(WR_CYCLES - 1);
                            ram_address     <= req_addr;
                            ram_data_out    <= req_wdata;
                            ram_chip_select <= 1'b1;
                            ram_write       <= 1'b1;
                            ram_data_oe     <= 1'b1;
                        end else begin
                            state           <= READ;
                            count           <= 4'(RD_LATENCY - 1);
                            ram_address     <= req_addr;
                            ram_chip_select <= 1'b1;
                        end
                    end
                end

                // oe falls together with write so the data pin is released on the same edge.
                WRITE: begin
                    if (count == 4'd0) begin
                        state           <= RESP;
                        ram_chip_select <= 1'b0;
                        ram_write       <= 1'b0;
                        ram_data_oe     <= 1'b0;
                        ram_address     <= '0;
                        ram_data_out    <= '0;
                        rsp_valid       <= 1'b1;
                        rsp_error       <= 1'b0;
                        rsp_was_write   <= 1'b1;
                        rsp_rdata       <= '0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                READ: begin
                    if (count == 4'd0) begin
                        state           <= RESP;
                        ram_chip_select <= 1'b0;
                        ram_address     <= '0;
                        rsp_valid       <= 1'b1;
                        rsp_error       <= 1'b0;
                        rsp_was_write   <= 1'b0;
                        rsp_rdata       <= ram_data_in;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state         <= IDLE;
                        rsp_valid     <= 1'b0;
                        rsp_error     <= 1'b0;
                        rsp_was_write <= 1'b0;
                        rsp_rdata     <= '0;
                        req_ready     <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: randomized requests against a word-array
// reference model, with a RAM model that only presents read data after the full access time.

module tb_ram_access_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 421;
    localparam int AW    = 9;
    localparam int RDL   = 4;
    localparam int WRC   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_was_write;
    logic [AW-1:0] ram_address;
    logic          ram_write;
    logic          ram_chip_select;
    logic [DW-1:0] ram_data_out;
    logic          ram_data_oe;
    logic [DW-1:0] ram_data_in;

    always #5 clk = ~clk;

    ram_access_ctrl #(
        .DATA_WIDTH(DW),
        .RAM_DEPTH (DEPTH),
        .RD_LATENCY(RDL),
        .WR_CYCLES (WRC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .rsp_was_write  (rsp_was_write),
        .ram_address    (ram_address),
        .ram_write      (ram_write),
        .ram_chip_select(ram_chip_select),
        .ram_data_out   (ram_data_out),
        .ram_data_oe    (ram_data_oe),
        .ram_data_in    (ram_data_in)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          ww;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] ram_mem [0:511];
    int            rd_age = 0;
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            stall = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic          cur_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data is garbage until chip_select has been held for the full read time.
    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < 512; i++) begin
            v = $urandom;
            ram_mem[i] <= v;
            if (i < DEPTH) ref_mem[i] = v;
        end
        forever begin
            @(posedge clk);
            if (ram_chip_select && ram_write && ram_data_oe) ram_mem[ram_address] <= ram_data_out;
            if (ram_chip_select && !ram_write) rd_age <= rd_age + 1;
            else rd_age <= 0;
        end
    end

    assign ram_data_in = (ram_chip_select && !ram_write && rd_age >= RDL - 1)
                         ? ram_mem[ram_address] : 32'hBAD0_0BAD;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        exp_t e;
        int   guard;
        guard     = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("accept timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        if (int'(addr) >= DEPTH) begin
            e.rdata = '0; e.err = 1'b1; e.ww = wr; e.lat = 1;
        end else if (wr) begin
            ref_mem[addr] = wd;
            e.rdata = '0; e.err = 1'b0; e.ww = 1'b1; e.lat = WRC + 1;
        end else begin
            e.rdata = ref_mem[addr]; e.err = 1'b0; e.ww = 1'b0; e.lat = RDL + 1;
        end
        sb.push_back(e);
        cur_addr  = addr;
        cur_wdata = wd;
        cur_err   = (int'(addr) >= DEPTH);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on each new response and checks pin-level protocol every cycle.
    initial begin
        exp_t          e;
        logic          prev_hold = 1'b0;
        logic          expect_idle = 1'b0;
        logic          run_write = 1'b0;
        int            run = 0;
        logic [DW-1:0] held_rdata = '0;
        logic          held_err = 1'b0;
        logic          held_ww = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold   = 1'b0;
                expect_idle = 1'b0;
                run         = 0;
            end else begin
                if (expect_idle) begin
                    checkOutput("req_ready after handshake", 64'(req_ready), 64'd1);
                    checkOutput("rsp_valid after handshake", 64'(rsp_valid), 64'd0);
                    expect_idle = 1'b0;
                end
                if (rsp_valid) begin
                    checkOutput("req_ready in resp", 64'(req_ready), 64'd0);
                    if (prev_hold) begin
                        checkOutput("held rsp_rdata", 64'(rsp_rdata), 64'(held_rdata));
                        checkOutput("held rsp_error", 64'(rsp_error), 64'(held_err));
                        checkOutput("held rsp_was_write", 64'(rsp_was_write), 64'(held_ww));
                    end else if (sb.size() == 0) begin
                        checkOutput("unexpected response", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        checkOutput("rsp_error", 64'(rsp_error), 64'(e.err));
                        checkOutput("rsp_was_write", 64'(rsp_was_write), 64'(e.ww));
                        checkOutput("latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    held_rdata = rsp_rdata;
                    held_err   = rsp_error;
                    held_ww    = rsp_was_write;
                    prev_hold  = !rsp_ready;
                    if (rsp_ready) expect_idle = 1'b1;
                end else begin
                    prev_hold = 1'b0;
                end

                if (ram_chip_select) begin
                    if (run == 0) begin
                        run_write = ram_write;
                        checkOutput("cs on error request", 64'(cur_err), 64'd0);
                    end
                    run++;
                    checkOutput("oe follows write", 64'(ram_data_oe), 64'(ram_write));
                    checkOutput("write steady in pulse", 64'(ram_write), 64'(run_write));
                    checkOutput("ram_address", 64'(ram_address), 64'(cur_addr));
                    checkOutput("req_ready during access", 64'(req_ready), 64'd0);
                    if (ram_write) checkOutput("ram_data_out", 64'(ram_data_out), 64'(cur_wdata));
                end else begin
                    checkOutput("oe idle", 64'(ram_data_oe), 64'd0);
                    checkOutput("write idle", 64'(ram_write), 64'd0);
                    if (run > 0) begin
                        if (run_write) checkOutput("write pulse width", 64'(run), 64'(WRC));
                        else checkOutput("read pulse width", 64'(run), 64'(RDL));
                        run = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        int            guard;

        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset req_ready", 64'(req_ready), 64'd1);
            checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
            checkOutput("reset chip_select", 64'(ram_chip_select), 64'd0);
            checkOutput("reset ram_write", 64'(ram_write), 64'd0);
            checkOutput("reset ram_data_oe", 64'(ram_data_oe), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 9'h03C, 32'h0000_00A5);
        applyStimulus(1'b0, 9'h03C, 32'h0);
        applyStimulus(1'b0, 9'd430, 32'h0);
        applyStimulus(1'b0, 9'd420, 32'h0);
        applyStimulus(1'b1, 9'd420, 32'hCAFE_F00D);
        applyStimulus(1'b0, 9'd420, 32'h0);
        applyStimulus(1'b1, 9'd421, 32'h1234_5678);
        applyStimulus(1'b0, 9'd511, 32'h0);
        applyStimulus(1'b0, 9'd0, 32'h0);

        // Long response stall on a read, with the next request already waiting.
        applyStimulus(1'b0, 9'h03C, 32'h0);
        stall = RDL + 6;
        applyStimulus(1'b1, 9'h010, 32'h5A5A_5A5A);

        // Abort a read during its second chip-select cycle.
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        applyStimulus(1'b0, 9'h010, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort chip_select", 64'(ram_chip_select), 64'd0);
        checkOutput("abort ram_write", 64'(ram_write), 64'd0);
        checkOutput("abort ram_data_oe", 64'(ram_data_oe), 64'd0);
        checkOutput("abort ram_address", 64'(ram_address), 64'd0);
        checkOutput("abort rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("abort req_ready", 64'(req_ready), 64'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("no rsp after abort", 64'(rsp_valid), 64'd0);
        end
        applyStimulus(1'b0, 9'h010, 32'h0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0:       a = AW'($urandom_range(DEPTH, 511));
                1:       a = AW'($urandom_range(DEPTH - 2, DEPTH));
                default: a = AW'($urandom_range(0, DEPTH - 1));
            endcase
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("responses outstanding", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
